// File: rtl/i2c_master_xfer_seq.sv
// I2C register-access sequencer: expands one host request into byte-controller commands.
// Define I2C_SEQ_ADDR16_EN for 16-bit register addresses (REGH state present, MSB first).
module i2c_master_xfer_seq #(
    parameter int MAX_LEN_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 req_i,
    input  logic                 rnw_i,
    input  logic [6:0]           dev_addr_i,
`ifdef I2C_SEQ_ADDR16_EN
    input  logic [15:0]          reg_addr_i,
`else
    input  logic [7:0]           reg_addr_i,
`endif
    input  logic [MAX_LEN_W-1:0] len_i,
    input  logic [7:0]           wdat_i,
    input  logic                 wvalid_i,
    output logic                 wready_o,
    output logic [7:0]           rdat_o,
    output logic                 rvalid_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           err_o,
    output logic                 bc_start_o,
    output logic                 bc_stop_o,
    output logic                 bc_read_o,
    output logic                 bc_write_o,
    output logic                 bc_ack_o,
    output logic [7:0]           bc_dat_o,
    input  logic                 bc_cmd_ack_i,
    input  logic                 bc_ack_i,
    input  logic [7:0]           bc_dat_i,
    input  logic                 bc_al_i
);
`ifdef I2C_SEQ_ADDR16_EN
    localparam int RA_W = 16;
`else
    localparam int RA_W = 8;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEVW,
`ifdef I2C_SEQ_ADDR16_EN
        S_REGH,
`endif
        S_REGL,
        S_WDATA,
        S_RSTART,
        S_RDATA,
        S_STOP,
        S_DONE
    } state_t;

    // Command vector layout: {start, stop, read, write, ack}
    localparam logic [4:0] CMD_NONE = 5'b00000;
    localparam logic [4:0] CMD_SW   = 5'b10010;
    localparam logic [4:0] CMD_W    = 5'b00010;
    localparam logic [4:0] CMD_WP   = 5'b01010;
    localparam logic [4:0] CMD_R    = 5'b00100;
    localparam logic [4:0] CMD_RL   = 5'b01101;
    localparam logic [4:0] CMD_P    = 5'b01000;

    state_t               state_reg;
    logic [4:0]           cmd_reg;
    logic [7:0]           dat_reg;
    logic [6:0]           dev_reg;
    logic [RA_W-1:0]      ra_reg;
    logic                 rnw_reg;
    logic [MAX_LEN_W-1:0] cnt_reg;
    logic                 wready_reg;
    logic                 rvalid_reg;
    logic [7:0]           rdat_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [1:0]           err_reg;
    logic                 last_byte;

    assign last_byte = (cnt_reg == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg  <= S_IDLE;
            cmd_reg    <= CMD_NONE;
            dat_reg    <= 8'h00;
            dev_reg    <= 7'h00;
            ra_reg     <= '0;
            rnw_reg    <= 1'b0;
            cnt_reg    <= '0;
            wready_reg <= 1'b0;
            rvalid_reg <= 1'b0;
            rdat_reg   <= 8'h00;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 2'b00;
        end else begin
            wready_reg <= 1'b0;
            rvalid_reg <= 1'b0;
            done_reg   <= 1'b0;
            // Lost arbitration wins over any ack; the byte controller idles itself.
            if (bc_al_i && state_reg != S_IDLE && state_reg != S_DONE) begin
                cmd_reg   <= CMD_NONE;
                dat_reg   <= 8'h00;
                err_reg   <= 2'b11;
                done_reg  <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= S_DONE;
            end else begin
                case (state_reg)
                    S_IDLE: if (req_i) begin
                        dev_reg   <= dev_addr_i;
                        ra_reg    <= reg_addr_i;
                        rnw_reg   <= rnw_i;
                        cnt_reg   <= len_i;
                        err_reg   <= 2'b00;
                        busy_reg  <= 1'b1;
                        cmd_reg   <= CMD_SW;
                        dat_reg   <= {dev_addr_i, 1'b0};
                        state_reg <= S_DEVW;
                    end
                    S_DEVW: if (bc_cmd_ack_i) begin
                        if (bc_ack_i) begin
                            err_reg   <= 2'b01;
                            cmd_reg   <= CMD_P;
                            dat_reg   <= 8'h00;
                            state_reg <= S_STOP;
                        end else begin
                            cmd_reg   <= CMD_W;
`ifdef I2C_SEQ_ADDR16_EN
                            dat_reg   <= ra_reg[15:8];
                            state_reg <= S_REGH;
`else
                            dat_reg   <= ra_reg[7:0];
                            state_reg <= S_REGL;
`endif
                        end
                    end
`ifdef I2C_SEQ_ADDR16_EN
                    S_REGH: if (bc_cmd_ack_i) begin
                        if (bc_ack_i) begin
                            err_reg   <= 2'b10;
                            cmd_reg   <= CMD_P;
                            dat_reg   <= 8'h00;
                            state_reg <= S_STOP;
                        end else begin
                            cmd_reg   <= CMD_W;
                            dat_reg   <= ra_reg[7:0];
                            state_reg <= S_REGL;
                        end
                    end
`endif
                    S_REGL: if (bc_cmd_ack_i) begin
                        if (bc_ack_i) begin
                            err_reg   <= 2'b10;
                            cmd_reg   <= CMD_P;
                            dat_reg   <= 8'h00;
                            state_reg <= S_STOP;
                        end else if (rnw_reg) begin
                            cmd_reg   <= CMD_SW;
                            dat_reg   <= {dev_reg, 1'b1};
                            state_reg <= S_RSTART;
                        end else begin
                            cmd_reg   <= CMD_NONE;
                            dat_reg   <= 8'h00;
                            state_reg <= S_WDATA;
                        end
                    end
                    // Idle command slot means we are waiting for the host's next byte.
                    S_WDATA: if (cmd_reg == CMD_NONE) begin
                        if (wvalid_i) begin
                            wready_reg <= 1'b1;
                            cmd_reg    <= last_byte ? CMD_WP : CMD_W;
                            dat_reg    <= wdat_i;
                        end
                    end else if (bc_cmd_ack_i) begin
                        cmd_reg <= CMD_NONE;
                        dat_reg <= 8'h00;
                        if (bc_ack_i && !last_byte) begin
                            err_reg   <= 2'b10;
                            cmd_reg   <= CMD_P;
                            state_reg <= S_STOP;
                        end else if (last_byte) begin
                            if (bc_ack_i) err_reg <= 2'b10;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= S_DONE;
                        end else begin
                            cnt_reg <= cnt_reg - MAX_LEN_W'(1);
                        end
                    end
                    S_RSTART: if (bc_cmd_ack_i) begin
                        dat_reg <= 8'h00;
                        if (bc_ack_i) begin
                            err_reg   <= 2'b01;
                            cmd_reg   <= CMD_P;
                            state_reg <= S_STOP;
                        end else begin
                            cmd_reg   <= last_byte ? CMD_RL : CMD_R;
                            state_reg <= S_RDATA;
                        end
                    end
                    S_RDATA: if (bc_cmd_ack_i) begin
                        rvalid_reg <= 1'b1;
                        rdat_reg   <= bc_dat_i;
                        if (last_byte) begin
                            cmd_reg   <= CMD_NONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= S_DONE;
                        end else begin
                            cnt_reg <= cnt_reg - MAX_LEN_W'(1);
                            cmd_reg <= (cnt_reg == MAX_LEN_W'(1)) ? CMD_RL : CMD_R;
                        end
                    end
                    S_STOP: if (bc_cmd_ack_i) begin
                        cmd_reg   <= CMD_NONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_DONE;
                    end
                    S_DONE:  state_reg <= S_IDLE;
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign bc_start_o = cmd_reg[4];
    assign bc_stop_o  = cmd_reg[3];
    assign bc_read_o  = cmd_reg[2];
    assign bc_write_o = cmd_reg[1];
    assign bc_ack_o   = cmd_reg[0];
    assign bc_dat_o   = dat_reg;
    assign wready_o   = wready_reg;
    assign rvalid_o   = rvalid_reg;
    assign rdat_o     = rdat_reg;
    assign busy_o     = busy_reg;
    assign done_o     = done_reg;
    assign err_o      = err_reg;

endmodule

// File: tb/tb_i2c_master_xfer_seq.sv
// Bench for i2c_master_xfer_seq: table of directed transfers against a scripted byte-controller responder.
module tb_i2c_master_xfer_seq;
`ifdef I2C_SEQ_ADDR16_EN
    localparam int RA_W = 16;
    localparam int PRE  = 3;
`else
    localparam int RA_W = 8;
    localparam int PRE  = 2;
`endif
    localparam logic [12:0] C_R  = 13'b00100_00000000;
    localparam logic [12:0] C_RP = 13'b01101_00000000;
    localparam logic [12:0] C_P  = 13'b01000_00000000;

    logic            clk_i = 1'b0;
    logic            rst_n_i, req_i, rnw_i;
    logic [6:0]      dev_addr_i;
    logic [RA_W-1:0] reg_addr_i;
    logic [3:0]      len_i;
    logic [7:0]      wdat_i;
    logic            wvalid_i, wready_o;
    logic [7:0]      rdat_o;
    logic            rvalid_o, busy_o, done_o;
    logic [1:0]      err_o;
    logic            bc_start_o, bc_stop_o, bc_read_o, bc_write_o, bc_ack_o;
    logic [7:0]      bc_dat_o;
    logic            bc_cmd_ack_i, bc_ack_i;
    logic [7:0]      bc_dat_i;
    logic            bc_al_i;

    i2c_master_xfer_seq dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .rnw_i(rnw_i),
        .dev_addr_i(dev_addr_i), .reg_addr_i(reg_addr_i), .len_i(len_i),
        .wdat_i(wdat_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rdat_o(rdat_o), .rvalid_o(rvalid_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .bc_start_o(bc_start_o), .bc_stop_o(bc_stop_o),
        .bc_read_o(bc_read_o), .bc_write_o(bc_write_o), .bc_ack_o(bc_ack_o),
        .bc_dat_o(bc_dat_o), .bc_cmd_ack_i(bc_cmd_ack_i), .bc_ack_i(bc_ack_i),
        .bc_dat_i(bc_dat_i), .bc_al_i(bc_al_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic             rnw;
        logic [6:0]       dev;
        logic [RA_W-1:0]  ra;
        logic [3:0]       len;
        logic [3:0][7:0]  dat;
        int               nack_idx;
        int               al_idx;
        int               stall;
        logic [1:0]       exp_err;
        int               exp_wr;
        int               exp_rv;
        int               exp_ncmd;
        logic [9:0][12:0] exp_cmd;
    } vec_t;

    vec_t vecs [10];
    vec_t cur;
    int   nv = 0;
    int   total = 0, bad = 0;

    int          cap_cnt, wait_cnt, wr_idx, rd_idx, rv_cnt, done_cnt, stall_left, viol, stab_err;
    logic [12:0] cap [10];
    logic [12:0] first_cmd;
    logic [7:0]  rbuf [4];
    logic [1:0]  err_cap;
    logic        busy_at_done, al_pending, al_ok;
    logic        cmd_any;
    logic [12:0] cur_cmd;

    assign cmd_any = bc_start_o | bc_stop_o | bc_read_o | bc_write_o;
    assign cur_cmd = {bc_start_o, bc_stop_o, bc_read_o, bc_write_o, bc_ack_o, bc_dat_o};

    function automatic logic [12:0] c_sw(input logic [7:0] d); return {5'b10010, d}; endfunction
    function automatic logic [12:0] c_w (input logic [7:0] d); return {5'b00010, d}; endfunction
    function automatic logic [12:0] c_wp(input logic [7:0] d); return {5'b01010, d}; endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic rnw, input logic [6:0] dev, input logic [7:0] ra_lo,
                           input logic [3:0] len, input logic [31:0] dat, input int nack,
                           input int al, input int stall, input logic [1:0] err,
                           input int nwr, input int nrv);
        vec_t v;
        v = '0;
        v.rnw = rnw; v.dev = dev; v.len = len; v.dat = dat;
`ifdef I2C_SEQ_ADDR16_EN
        v.ra = {8'h12, ra_lo};
`else
        v.ra = ra_lo;
`endif
        v.nack_idx = nack; v.al_idx = al; v.stall = stall;
        v.exp_err = err; v.exp_wr = nwr; v.exp_rv = nrv; v.exp_ncmd = 0;
        vecs[nv] = v;
        nv++;
    endtask

    task automatic add_cmd(input logic [12:0] c);
        vecs[nv-1].exp_cmd[vecs[nv-1].exp_ncmd] = c;
        vecs[nv-1].exp_ncmd = vecs[nv-1].exp_ncmd + 1;
    endtask

    task automatic add_reg(input logic [7:0] lo);
`ifdef I2C_SEQ_ADDR16_EN
        add_cmd(c_w(8'h12));
`endif
        add_cmd(c_w(lo));
    endtask

    // Byte-controller responder and output monitor, evaluated on every falling edge.
    initial begin
        bc_cmd_ack_i = 0; bc_ack_i = 0; bc_dat_i = 0; bc_al_i = 0;
        wvalid_i = 0; wdat_i = 0; al_pending = 0; wait_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (done_o) begin done_cnt++; err_cap = err_o; busy_at_done = busy_o; end
            if (wready_o) wr_idx++;
            if (rvalid_o) begin
                if (rv_cnt < 4) rbuf[rv_cnt] = rdat_o;
                rv_cnt++;
            end
            if (cur.stall > 0 && cap_cnt >= PRE && wr_idx == 0 && !wvalid_i && cmd_any) viol++;
            if (stall_left > 0 && cap_cnt >= PRE) stall_left--;
            wvalid_i = !cur.rnw && stall_left == 0;
            wdat_i   = (wr_idx < 4) ? cur.dat[wr_idx] : 8'h00;
            if (al_pending) begin
                bc_al_i = 0; al_pending = 0;
                al_ok = !cmd_any && done_o && err_o == 2'b11;
            end else if (bc_cmd_ack_i) begin
                bc_cmd_ack_i = 0; bc_ack_i = 0; wait_cnt = 0;
            end else if (cmd_any) begin
                if (wait_cnt == 0) first_cmd = cur_cmd;
                else if (cur_cmd !== first_cmd) stab_err++;
                wait_cnt++;
                if (wait_cnt == 3) begin
                    if (cap_cnt == cur.al_idx) begin
                        bc_al_i = 1; al_pending = 1;
                    end else begin
                        if (cap_cnt < 10) cap[cap_cnt] = cur_cmd;
                        bc_ack_i = (cap_cnt == cur.nack_idx);
                        if (bc_read_o) begin
                            bc_dat_i = (rd_idx < 4) ? cur.dat[rd_idx] : 8'h00;
                            rd_idx++;
                        end
                        bc_cmd_ack_i = 1;
                        cap_cnt++;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic start_xfer(input vec_t v);
        @(negedge clk_i); #1;
        cur = v; cap_cnt = 0; wr_idx = 0; rd_idx = 0; rv_cnt = 0; done_cnt = 0;
        stall_left = v.stall; viol = 0; stab_err = 0; al_ok = 0; err_cap = 0; busy_at_done = 1;
        for (int k = 0; k < 10; k++) cap[k] = '0;
        for (int k = 0; k < 4; k++) rbuf[k] = '0;
        req_i = 1; rnw_i = v.rnw; dev_addr_i = v.dev; reg_addr_i = v.ra; len_i = v.len;
        @(negedge clk_i); #1;
        req_i = 0;
    endtask

    task automatic wait_done(input int i);
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin @(negedge clk_i); #1; cyc++; end
        chk($sformatf("v%0d_done_seen", i), 32'(done_cnt > 0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst_n_i = 0; req_i = 0; rnw_i = 0; dev_addr_i = 0; reg_addr_i = 0; len_i = 0;
        cur = '0;
        cap_cnt = 0; wr_idx = 0; rd_idx = 0; rv_cnt = 0; done_cnt = 0; stall_left = 0;
        viol = 0; stab_err = 0; al_ok = 0;

        add_vec(0, 7'h50, 8'h10, 1, 32'h00005AA5, -1, -1, 0, 2'b00, 2, 0);
        add_cmd(c_sw(8'hA0)); add_reg(8'h10); add_cmd(c_w(8'hA5)); add_cmd(c_wp(8'h5A));
        add_vec(1, 7'h50, 8'h22, 2, 32'h00332211, -1, -1, 0, 2'b00, 0, 3);
        add_cmd(c_sw(8'hA0)); add_reg(8'h22); add_cmd(c_sw(8'hA1)); add_cmd(C_R); add_cmd(C_R); add_cmd(C_RP);
        add_vec(0, 7'h3C, 8'h01, 1, 32'h0000BEEF, 0, -1, 0, 2'b01, 0, 0);
        add_cmd(c_sw(8'h78)); add_cmd(C_P);
        add_vec(0, 7'h21, 8'h05, 0, 32'h000000C3, -1, -1, 20, 2'b00, 1, 0);
        add_cmd(c_sw(8'h42)); add_reg(8'h05); add_cmd(c_wp(8'hC3));
        add_vec(1, 7'h50, 8'h22, 2, 32'h00332211, -1, PRE + 2, 0, 2'b11, 0, 1);
        add_cmd(c_sw(8'hA0)); add_reg(8'h22); add_cmd(c_sw(8'hA1)); add_cmd(C_R);
        add_vec(0, 7'h50, 8'h7F, 3, 32'h44332211, PRE - 1, -1, 0, 2'b10, 0, 0);
        add_cmd(c_sw(8'hA0)); add_reg(8'h7F); add_cmd(C_P);
        add_vec(0, 7'h11, 8'h00, 0, 32'h000000EE, PRE, -1, 0, 2'b10, 1, 0);
        add_cmd(c_sw(8'h22)); add_reg(8'h00); add_cmd(c_wp(8'hEE));
        add_vec(1, 7'h50, 8'h40, 0, 32'h0000009C, -1, -1, 0, 2'b00, 0, 1);
        add_cmd(c_sw(8'hA0)); add_reg(8'h40); add_cmd(c_sw(8'hA1)); add_cmd(C_RP);
        add_vec(1, 7'h50, 8'h22, 1, 32'h00000000, PRE, -1, 0, 2'b01, 0, 0);
        add_cmd(c_sw(8'hA0)); add_reg(8'h22); add_cmd(c_sw(8'hA1)); add_cmd(C_P);
        add_vec(0, 7'h50, 8'h10, 2, 32'h00CCBBAA, PRE, -1, 0, 2'b10, 1, 0);
        add_cmd(c_sw(8'hA0)); add_reg(8'h10); add_cmd(c_w(8'hAA)); add_cmd(C_P);

        repeat (2) @(negedge clk_i);
        #1;
        chk("reset_outputs", {wready_o, rdat_o, rvalid_o, busy_o, done_o, err_o,
                              bc_start_o, bc_stop_o, bc_read_o, bc_write_o, bc_ack_o, bc_dat_o}, 32'd0);
        rst_n_i = 1;
        @(negedge clk_i); #1;
        chk("idle_after_reset", {busy_o, done_o, cmd_any}, 32'd0);

        for (int i = 0; i < nv; i++) begin
            start_xfer(vecs[i]);
            chk($sformatf("v%0d_first_cmd", i), {bc_start_o, bc_write_o, busy_o, done_o, bc_dat_o},
                {4'b1110, vecs[i].dev, 1'b0});
            if (vecs[i].stall > 0) begin
                repeat (5) @(negedge clk_i);
                #1;
                req_i = 1; rnw_i = 1; dev_addr_i = 7'h7F;
                @(negedge clk_i); #1;
                req_i = 0;
            end
            wait_done(i);
            chk($sformatf("v%0d_err", i), err_cap, vecs[i].exp_err);
            chk($sformatf("v%0d_busy_at_done", i), busy_at_done, 1'b0);
            chk($sformatf("v%0d_ncmd", i), cap_cnt, vecs[i].exp_ncmd);
            for (int k = 0; k < vecs[i].exp_ncmd; k++) begin
                logic [12:0] e;
                logic [12:0] a;
                e = vecs[i].exp_cmd[k];
                a = cap[k];
                if (!e[9]) a = {a[12:8], 8'h00};
                chk($sformatf("v%0d_cmd%0d", i, k), a, e);
            end
            chk($sformatf("v%0d_wready_cnt", i), wr_idx, vecs[i].exp_wr);
            chk($sformatf("v%0d_rvalid_cnt", i), rv_cnt, vecs[i].exp_rv);
            for (int k = 0; k < vecs[i].exp_rv && k < 4; k++)
                chk($sformatf("v%0d_rdat%0d", i, k), rbuf[k], vecs[i].dat[k]);
            chk($sformatf("v%0d_cmd_stable", i), stab_err, 0);
            if (vecs[i].stall > 0) begin
                chk($sformatf("v%0d_stall_idle_bus", i), viol, 0);
                repeat (4) @(negedge clk_i);
                #1;
                chk($sformatf("v%0d_busy_req_ignored", i), {busy_o, cmd_any}, 2'b00);
            end
            if (vecs[i].al_idx >= 0)
                chk($sformatf("v%0d_al_clear", i), al_ok, 1'b1);
            $display("xfer %0d: rnw=%0d dev=%02h len=%0d err=%0d cmds=%0d wready=%0d rvalid=%0d",
                     i, vecs[i].rnw, vecs[i].dev, vecs[i].len, err_cap, cap_cnt, wr_idx, rv_cnt);
        end

        // Asynchronous reset while the first read byte is in flight.
        start_xfer(vecs[1]);
        cyc = 0;
        while (cap_cnt < PRE + 2 && cyc < 500) begin @(negedge clk_i); #1; cyc++; end
        chk("rst_mid_reached_rdata", 32'(cap_cnt >= PRE + 2), 32'd1);
        rst_n_i = 0; bc_cmd_ack_i = 0; bc_ack_i = 0;
        #1;
        chk("rst_mid_outputs", {wready_o, rdat_o, rvalid_o, busy_o, done_o, err_o,
                                bc_start_o, bc_stop_o, bc_read_o, bc_write_o, bc_ack_o, bc_dat_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        #1;
        rst_n_i = 1;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_mid_idle_after", {busy_o, done_o, cmd_any}, 32'd0);
        $display("xfer reset: mid-read reset, outputs busy=%0d cmd=%0d", busy_o, cmd_any);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
